// File: rtl/regbank32_writer.sv
// regbank32_writer: write side of a 32 x N register bank (address decode, bulk-clear sweep, valid/ready write port).
// Latency: an accepted write shows on q the next cycle; a clear sweep zeroes one entry per cycle for 32 cycles.
// Backpressure: w_ready drops while clear is requested or a sweep runs; the sender holds its request. Macro REGBANK_ZERO_REG_EN makes entry 31 a hardwired zero.
module regbank32_writer #(
  parameter int N = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clear,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [4:0]      w_addr,
  input  logic [N-1:0]    w_data,
  output logic            busy,
  output logic [32*N-1:0] q
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t       state_q;
  logic [4:0]   ptr_q;
  logic         busy_q;
  logic [N-1:0] ent_q [32];
  logic [N-1:0] ent_d [32];
  logic [31:0]  wr_en_d;
  logic         w_accept;

  // Writes are only taken in IDLE when no clear is being requested.
  always_comb begin
    w_ready  = (state_q == IDLE) & ~clear;
    w_accept = w_valid & w_ready;
    wr_en_d  = w_accept ? (32'd1 << w_addr) : 32'd0;
    busy     = busy_q;
  end

  // Per-entry next value: a decoded write, or zero when the sweep pointer reaches it.
  always_comb begin
    for (int k = 0; k < 32; k++) begin
      ent_d[k] = ent_q[k];
      if (wr_en_d[k]) begin
        ent_d[k] = w_data;
      end
      if ((state_q == CLEAR) && (ptr_q == 5'(k))) begin
        ent_d[k] = '0;
      end
    end
`ifdef REGBANK_ZERO_REG_EN
    // Entry 31 is the zero register: accepted writes to it are dropped.
    ent_d[31] = '0;
`endif
  end

  // Entry storage; reset wipes every entry, aborting any sweep in progress.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 32; k++) begin
        ent_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 32; k++) begin
        ent_q[k] <= ent_d[k];
      end
    end
  end

  // Sweep FSM: IDLE waits for clear, CLEAR walks ptr 0..31 then returns to IDLE.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= 5'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear) begin
            state_q <= CLEAR;
            ptr_q   <= 5'd0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr_q == 5'd31) begin
            state_q <= IDLE;
            ptr_q   <= 5'd0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + 5'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ptr_q   <= 5'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Flatten entries onto the read-port bus.
  always_comb begin
    q = '0;
    for (int k = 0; k < 32; k++) begin
      q[k*N +: N] = ent_q[k];
    end
`ifdef REGBANK_ZERO_REG_EN
    q[31*N +: N] = '0;
`endif
  end

endmodule

// File: tb/tb_regbank32_writer.sv
// Bench for regbank32_writer: directed table, hand-written sweep/reset sequences and random traffic
// checked against an array-based model of the bank.
module tb_regbank32_writer;
  localparam int N = 8;
`ifdef REGBANK_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset, clear, w_valid, w_ready, busy;
  logic [4:0]      w_addr;
  logic [N-1:0]    w_data;
  logic [32*N-1:0] q;

  regbank32_writer #(.N(N)) dut (
    .clock(clock), .reset(reset), .clear(clear), .w_valid(w_valid), .w_ready(w_ready),
    .w_addr(w_addr), .w_data(w_data), .busy(busy), .q(q)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: entry contents plus number of sweep cycles still to run (0 = idle).
  logic [N-1:0] m_ent [32];
  int           m_left = 0;

  typedef struct {
    logic [4:0]   addr;
    logic [N-1:0] data;
    logic [N-1:0] exp;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string nm, input logic [32*N-1:0] act, input logic [32*N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [32*N-1:0] m_q();
    logic [32*N-1:0] r;
    for (int k = 0; k < 32; k++) r[k*N +: N] = m_ent[k];
    return r;
  endfunction

  function automatic logic [N-1:0] entry(input int k);
    return q[k*N +: N];
  endfunction

  // One clock with the currently driven inputs: check ready, advance the model, check outputs.
  task automatic cyc();
    #1;
    chk("w_ready", {255'd0, w_ready}, {255'd0, (m_left == 0) && !clear});
    if (!reset) begin
      for (int k = 0; k < 32; k++) m_ent[k] = '0;
      m_left = 0;
    end else if (m_left == 0) begin
      if (clear) m_left = 32;
      else if (w_valid && !(ZR && w_addr == 5'd31)) m_ent[w_addr] = w_data;
    end else begin
      m_ent[32 - m_left] = '0;
      m_left--;
    end
    @(posedge clock);
    #1;
    chk("q", q, m_q());
    chk("busy", {255'd0, busy}, {255'd0, m_left != 0});
  endtask

  task automatic wr(input logic [4:0] a, input logic [N-1:0] d);
    w_valid = 1'b1; w_addr = a; w_data = d;
    cyc();
    w_valid = 1'b0;
  endtask

  task automatic fill();
    for (int k = 0; k < 32; k++) wr(5'(k), N'(k + 1));
  endtask

  initial begin
    int cnt;
    int guard;
    vecs[0] = '{5'd0,  8'h3C, 8'h3C};
    vecs[1] = '{5'd1,  8'h00, 8'h00};
    vecs[2] = '{5'd16, 8'h80, 8'h80};
    vecs[3] = '{5'd30, 8'h7E, 8'h7E};
    vecs[4] = '{5'd15, 8'hFF, 8'hFF};
    vecs[5] = '{5'd8,  8'h01, 8'h01};
    vecs[6] = '{5'd31, 8'hFF, ZR ? 8'h00 : 8'hFF};
    vecs[7] = '{5'd31, 8'h5A, ZR ? 8'h00 : 8'h5A};

    reset = 1'b0; clear = 1'b0; w_valid = 1'b0; w_addr = '0; w_data = '0;
    for (int k = 0; k < 32; k++) m_ent[k] = '0;
    @(posedge clock);
    #1;
    cyc();                       // reset held: q=0, busy=0
    reset = 1'b1;

    // Single write to addr 5.
    w_valid = 1'b1; w_addr = 5'd5; w_data = 8'hA5;
    #1;
    chk("ready_a5", {255'd0, w_ready}, 256'd1);
    cyc();
    w_valid = 1'b0;
    chk("a5_entry", {248'd0, q[47:40]}, {248'd0, 8'hA5});
    chk("a5_others", q & ~({248'd0, 8'hFF} << 40), 256'd0);

    // Same address twice back to back: last write wins.
    wr(5'd3, 8'h11);
    wr(5'd3, 8'h22);
    chk("a3_last", {248'd0, q[31:24]}, {248'd0, 8'h22});

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].data);
      chk($sformatf("vec%0d", i), {248'd0, entry(vecs[i].addr)}, {248'd0, vecs[i].exp});
    end

    // Full sweep with a partial-clear snapshot and a busy-length count.
    fill();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    cnt = busy ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (busy) cnt++;
    end
    chk("partial", {168'd0, q[87:0]}, {168'd0, 8'h0B, 80'd0});
    guard = 0;
    while (busy && guard < 40) begin
      cyc();
      if (busy) cnt++;
      guard++;
    end
    chk("busy_len", 256'(cnt), 256'd32);
    chk("swept_q", q, 256'd0);
    #1;
    chk("ready_post", {255'd0, w_ready}, 256'd1);

    // Write held through a sweep lands on the first IDLE edge.
    fill();
    clear = 1'b1;
    w_valid = 1'b1; w_addr = 5'd7; w_data = 8'h5C;
    cyc();
    clear = 1'b0;
    guard = 0;
    while (busy && guard < 40) begin
      cyc();
      guard++;
    end
    chk("held_not_yet", {248'd0, entry(7)}, 256'd0);
    cyc();
    w_valid = 1'b0;
    chk("held_landed", {248'd0, entry(7)}, {248'd0, 8'h5C});

    // Reset in the middle of a sweep.
    fill();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    chk("pre_rst_e20", {248'd0, entry(20)}, {248'd0, 8'd21});
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    chk("rst_q", q, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    #1;
    chk("rst_ready", {255'd0, w_ready}, 256'd1);

    // Clear held high across sweep end: one-cycle IDLE gap then a new sweep.
    fill();
    clear = 1'b1;
    for (int i = 0; i < 70; i++) cyc();
    clear = 1'b0;
    guard = 0;
    while (busy && guard < 40) begin
      cyc();
      guard++;
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      reset   = ($urandom_range(0, 199) != 0);
      clear   = ($urandom_range(0, 39) == 0) || (clear && $urandom_range(0, 3) != 0);
      w_valid = $urandom_range(0, 3) != 0;
      w_addr  = 5'($urandom_range(0, 31));
      w_data  = N'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
